// File: rtl/lab_seq_pkg.sv
// Shared types and helpers for the HOLD-to-digitize sequencer.
package lab_seq_pkg;

  localparam int LAB_NBUF_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    DIGITIZE,
    WAIT_DONE,
    READY,
    RELEASE
  } lab_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lsb_idx(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/lab_idx_fifo.sv
// Synchronous index FIFO with occupancy count; DEPTH need not be a power of two.
module lab_idx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PW-1:0]               r_wr, r_rd;
  logic [CW-1:0]               r_cnt;
  logic                        w_push, w_pop;

  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i && (r_cnt != CW'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd];
  assign count_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/lab_hold_sequencer.sv
// HOLD edge capture, arrival-order queue and digitize/readout/release FSM.
// Optional done timeout enabled by defining LAB_DIGITIZE_TIMEOUT_EN.
module lab_hold_sequencer
  import lab_seq_pkg::*;
#(
  parameter int NBUF           = LAB_NBUF_DEF,
  parameter int BW             = $clog2(NBUF),
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NBUF-1:0] hold_i,
  output logic [NBUF-1:0] digitize_o,
  input  logic            done_i,
  output logic            event_ready_o,
  output logic [BW-1:0]   event_buf_o,
  input  logic            event_ack_i,
  output logic [NBUF-1:0] release_o,
  output logic            busy_o,
  output logic [BW:0]     pending_o,
  output logic [7:0]      dup_cnt_o,
  output logic            timeout_o
);

  lab_state_e      r_state, w_state_nxt;
  logic [NBUF-1:0] r_hold_prev, r_pend, r_mask;
  logic [NBUF-1:0] r_digitize, r_release;
  logic [BW-1:0]   r_cur, r_event_buf, w_cur_nxt, w_push_idx, w_head;
  logic            r_event_ready, r_busy;
  logic [7:0]      r_dup;
  logic [NBUF-1:0] w_rise, w_acc, w_dup, w_push_oh, w_cur_oh;
  logic            w_push, w_pop, w_empty, w_expire;
  logic [BW:0]     w_cnt;
  logic [4:0]      w_dup_n;
  logic [8:0]      w_dup_sum;

  // r_mask covers pending, queued and in-service buffers until their release.
  assign w_rise     = hold_i & ~r_hold_prev;
  assign w_acc      = w_rise & ~r_mask;
  assign w_dup      = w_rise & r_mask;
  assign w_push     = |r_pend;
  assign w_push_idx = BW'(lsb_idx(16'(r_pend)));
  assign w_push_oh  = w_push ? (NBUF'(1) << w_push_idx) : '0;
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_cur_nxt  = w_pop ? w_head : r_cur;
  assign w_cur_oh   = NBUF'(1) << w_cur_nxt;

  always_comb begin
    w_dup_n = '0;
    for (int i = 0; i < NBUF; i++) w_dup_n = w_dup_n + 5'(w_dup[i]);
  end
  assign w_dup_sum = {1'b0, r_dup} + 9'(w_dup_n);

  lab_idx_fifo #(.DEPTH(NBUF), .WIDTH(BW), .CW(BW + 1)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_push_idx),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_cnt),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_prev <= '1;
      r_pend      <= '0;
      r_mask      <= '0;
      r_dup       <= '0;
    end else begin
      r_hold_prev <= hold_i;
      r_pend      <= (r_pend & ~w_push_oh) | w_acc;
      r_mask      <= (r_mask & ~r_release) | w_acc;
      r_dup       <= (w_dup_sum > 9'd255) ? 8'hFF : w_dup_sum[7:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (!w_empty) w_state_nxt = DIGITIZE;
      DIGITIZE:  w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (done_i)        w_state_nxt = READY;
        else if (w_expire) w_state_nxt = RELEASE;
      end
      READY:     if (event_ack_i) w_state_nxt = RELEASE;
      RELEASE:   w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_cur         <= '0;
      r_digitize    <= '0;
      r_release     <= '0;
      r_event_ready <= 1'b0;
      r_event_buf   <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur         <= w_cur_nxt;
      r_digitize    <= (w_state_nxt == DIGITIZE) ? w_cur_oh : '0;
      r_release     <= (w_state_nxt == RELEASE) ? w_cur_oh : '0;
      r_event_ready <= (w_state_nxt == READY);
      r_event_buf   <= (w_state_nxt == READY) ? w_cur_nxt : '0;
      r_busy        <= (w_state_nxt != IDLE) || w_push || (w_cnt != '0);
    end
  end

`ifdef LAB_DIGITIZE_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  assign w_expire = (r_to_cnt == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == WAIT_DONE && !done_i && !w_expire) ? r_to_cnt + 1'b1 : '0;
      if (r_state == WAIT_DONE && !done_i && w_expire) r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  logic [15:0] w_unused_to;
  assign w_unused_to = 16'(TIMEOUT_CYCLES);
  assign w_expire    = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  assign digitize_o    = r_digitize;
  assign release_o     = r_release;
  assign event_ready_o = r_event_ready;
  assign event_buf_o   = r_event_buf;
  assign busy_o        = r_busy;
  assign pending_o     = w_cnt;
  assign dup_cnt_o     = r_dup;

endmodule

// File: tb/tb_lab_hold_sequencer.sv
// Directed bench: NBUF=4 instance for the main scenarios, NBUF=8 instance for the burst case.
module tb_lab_hold_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] a_hold = '0, a_dig, a_rel;
  logic       a_done = 0, a_ack = 0, a_rdy, a_busy, a_to;
  logic [1:0] a_buf;
  logic [2:0] a_pend;
  logic [7:0] a_dup;

  logic [7:0] b_hold = '0, b_dig, b_rel, b_dup;
  logic       b_done = 0, b_ack = 0, b_rdy, b_busy, b_to;
  logic [2:0] b_buf;
  logic [3:0] b_pend;

  int checks = 0;
  int errors = 0;

  lab_hold_sequencer #(.NBUF(4), .TIMEOUT_CYCLES(100)) dut_a (
    .clk_i(clk), .rst_i(rst), .hold_i(a_hold), .digitize_o(a_dig), .done_i(a_done),
    .event_ready_o(a_rdy), .event_buf_o(a_buf), .event_ack_i(a_ack), .release_o(a_rel),
    .busy_o(a_busy), .pending_o(a_pend), .dup_cnt_o(a_dup), .timeout_o(a_to)
  );

  lab_hold_sequencer #(.NBUF(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .hold_i(b_hold), .digitize_o(b_dig), .done_i(b_done),
    .event_ready_o(b_rdy), .event_buf_o(b_buf), .event_ack_i(b_ack), .release_o(b_rel),
    .busy_o(b_busy), .pending_o(b_pend), .dup_cnt_o(b_dup), .timeout_o(b_to)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    checks++; if ({a_dig, a_rdy, a_buf, a_rel, a_busy, a_dup, a_to} !== '0) begin errors++; $display("FAIL reset_a_outputs: got %h want 0", {a_dig, a_rdy, a_buf, a_rel, a_busy, a_dup, a_to}); end
    checks++; if (a_pend !== 3'd0) begin errors++; $display("FAIL reset_a_pending: got %0d want 0", a_pend); end
    checks++; if ({b_dig, b_rdy, b_buf, b_rel, b_busy, b_pend, b_dup, b_to} !== '0) begin errors++; $display("FAIL reset_b_outputs: got %h want 0", {b_dig, b_rdy, b_buf, b_rel, b_busy, b_pend, b_dup, b_to}); end
  endtask

  task automatic test_single();
    a_hold = 4'b0100;
    tick(2);
    checks++; if (a_pend !== 3'd1) begin errors++; $display("FAIL single_pend_n2: got %0d want 1", a_pend); end
    checks++; if (a_dig !== 4'b0000) begin errors++; $display("FAIL single_dig_early: got %b want 0000", a_dig); end
    tick();
    checks++; if (a_dig !== 4'b0100) begin errors++; $display("FAIL single_dig: got %b want 0100", a_dig); end
    checks++; if (a_pend !== 3'd0) begin errors++; $display("FAIL single_pend_n3: got %0d want 0", a_pend); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", a_busy); end
    tick();
    checks++; if (a_dig !== 4'b0000) begin errors++; $display("FAIL single_dig_pulse: got %b want 0000", a_dig); end
    tick(6);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", a_rdy); end
    checks++; if (a_buf !== 2'd2) begin errors++; $display("FAIL single_buf: got %0d want 2", a_buf); end
    tick(3);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    checks++; if (a_rel !== 4'b0100) begin errors++; $display("FAIL single_release: got %b want 0100", a_rel); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL single_ready_clr: got %b want 0", a_rdy); end
    tick();
    checks++; if (a_rel !== 4'b0000) begin errors++; $display("FAIL single_release_pulse: got %b want 0000", a_rel); end
    a_hold = '0;
    tick(2);
  endtask

  task automatic test_simultaneous();
    a_hold = 4'b1010;
    tick(3);
    checks++; if (a_dig !== 4'b0010) begin errors++; $display("FAIL simul_dig1: got %b want 0010", a_dig); end
    checks++; if (a_pend !== 3'd1) begin errors++; $display("FAIL simul_pend1: got %0d want 1", a_pend); end
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++; if (a_buf !== 2'd1) begin errors++; $display("FAIL simul_buf1: got %0d want 1", a_buf); end
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    checks++; if (a_rel !== 4'b0010) begin errors++; $display("FAIL simul_rel1: got %b want 0010", a_rel); end
    tick(2);
    checks++; if (a_dig !== 4'b1000) begin errors++; $display("FAIL simul_dig3: got %b want 1000", a_dig); end
    checks++; if (a_pend !== 3'd0) begin errors++; $display("FAIL simul_pend0: got %0d want 0", a_pend); end
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++; if (a_buf !== 2'd3) begin errors++; $display("FAIL simul_buf3: got %0d want 3", a_buf); end
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    checks++; if (a_rel !== 4'b1000) begin errors++; $display("FAIL simul_rel3: got %b want 1000", a_rel); end
    a_hold = '0;
    tick(2);
  endtask

  task automatic test_duplicate();
    logic [3:0] seen;
    a_hold = 4'b0001;
    tick(3);
    checks++; if (a_dig !== 4'b0001) begin errors++; $display("FAIL dup_dig_first: got %b want 0001", a_dig); end
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    a_hold = 4'b0000;
    seen = '0;
    tick();
    a_hold = 4'b0001;
    tick();
    seen |= a_dig;
    checks++; if (a_dup !== 8'd1) begin errors++; $display("FAIL dup_count: got %0d want 1", a_dup); end
    tick();
    seen |= a_dig;
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    seen |= a_dig;
    checks++; if (a_rel !== 4'b0001) begin errors++; $display("FAIL dup_release: got %b want 0001", a_rel); end
    checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL dup_no_extra_dig: got %b want 0000", seen); end
    a_hold = 4'b0000;
    tick();
    a_hold = 4'b0001;
    tick(3);
    checks++; if (a_dig !== 4'b0001) begin errors++; $display("FAIL dup_redig: got %b want 0001", a_dig); end
    checks++; if (a_dup !== 8'd1) begin errors++; $display("FAIL dup_count_after: got %0d want 1", a_dup); end
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    checks++; if (a_rel !== 4'b0001) begin errors++; $display("FAIL dup_release2: got %b want 0001", a_rel); end
    a_hold = '0;
    tick(2);
  endtask

  task automatic test_nbuf8();
    logic [3:0] peak;
    peak = '0;
    b_hold = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 20 && b_dig == 8'h00; k++) begin
        tick();
        if (b_pend > peak) peak = b_pend;
      end
      checks++; if (b_dig !== 8'(1 << i)) begin errors++; $display("FAIL n8_dig[%0d]: got %b want %b", i, b_dig, 8'(1 << i)); end
      for (int k = 0; k < 8; k++) begin
        tick();
        if (b_pend > peak) peak = b_pend;
      end
      b_done = 1'b1;
      tick();
      b_done = 1'b0;
      checks++; if (b_buf !== 3'(i) || b_rdy !== 1'b1) begin errors++; $display("FAIL n8_buf[%0d]: got rdy=%b buf=%0d want rdy=1 buf=%0d", i, b_rdy, b_buf, i); end
      b_ack = 1'b1;
      tick();
      b_ack = 1'b0;
      checks++; if (b_rel !== 8'(1 << i)) begin errors++; $display("FAIL n8_rel[%0d]: got %b want %b", i, b_rel, 8'(1 << i)); end
    end
    checks++; if (peak !== 4'd7) begin errors++; $display("FAIL n8_pending_peak: got %0d want 7", peak); end
    checks++; if (b_dup !== 8'd0) begin errors++; $display("FAIL n8_dup: got %0d want 0", b_dup); end
    b_hold = '0;
    tick(2);
  endtask

  task automatic test_timeout();
    logic seen_rdy, seen_rel, seen_to;
    seen_rdy = 0; seen_rel = 0; seen_to = 0;
    a_hold = 4'b1000;
    tick(3);
    checks++; if (a_dig !== 4'b1000) begin errors++; $display("FAIL to_dig: got %b want 1000", a_dig); end
`ifdef LAB_DIGITIZE_TIMEOUT_EN
    for (int k = 0; k < 101; k++) begin
      tick();
      seen_rdy |= a_rdy; seen_rel |= |a_rel; seen_to |= a_to;
    end
    checks++; if ({seen_rel, seen_to} !== 2'b00) begin errors++; $display("FAIL to_early: got rel=%b to=%b want 0 0", seen_rel, seen_to); end
    tick();
    seen_rdy |= a_rdy;
    checks++; if (a_rel !== 4'b1000) begin errors++; $display("FAIL to_release: got %b want 1000", a_rel); end
    checks++; if (a_to !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", a_to); end
    tick(3);
    seen_rdy |= a_rdy;
    checks++; if (seen_rdy !== 1'b0) begin errors++; $display("FAIL to_no_ready: got %b want 0", seen_rdy); end
    checks++; if (a_to !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", a_to); end
`else
    for (int k = 0; k < 150; k++) begin
      tick();
      seen_rdy |= a_rdy; seen_rel |= |a_rel; seen_to |= a_to;
    end
    checks++; if ({seen_rdy, seen_rel, seen_to} !== 3'b000) begin errors++; $display("FAIL to_wait_forever: got rdy=%b rel=%b to=%b want 0 0 0", seen_rdy, seen_rel, seen_to); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++; if (a_rdy !== 1'b1 || a_buf !== 2'd3) begin errors++; $display("FAIL to_late_done: got rdy=%b buf=%0d want 1 3", a_rdy, a_buf); end
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    checks++; if (a_rel !== 4'b1000) begin errors++; $display("FAIL to_late_rel: got %b want 1000", a_rel); end
`endif
    a_hold = '0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    a_hold = 4'b0111;
    tick(4);
    checks++; if (a_pend !== 3'd2) begin errors++; $display("FAIL rmid_pend_before: got %0d want 2", a_pend); end
    rst = 1'b1;
    #1;
    checks++; if ({a_dig, a_rdy, a_buf, a_rel, a_busy, a_pend, a_dup, a_to} !== '0) begin errors++; $display("FAIL rmid_async_outputs: got %h want 0", {a_dig, a_rdy, a_buf, a_rel, a_busy, a_pend, a_dup, a_to}); end
    tick();
    rst = 1'b0;
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen |= a_dig;
    end
    checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL rmid_no_dig: got %b want 0000", seen); end
    checks++; if ({a_busy, a_pend} !== 4'b0000) begin errors++; $display("FAIL rmid_idle: got busy=%b pend=%0d want 0 0", a_busy, a_pend); end
    a_hold[1] = 1'b0;
    tick();
    a_hold[1] = 1'b1;
    tick(3);
    checks++; if (a_dig !== 4'b0010) begin errors++; $display("FAIL rmid_fresh_dig: got %b want 0010", a_dig); end
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    a_hold = '0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_duplicate();
    test_nbuf8();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
